// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the bit-serial magnitude comparator.
//   cmp_state_t : controller states (IDLE, SHIFT, DONE)
//   RES_*       : one-hot {gt,eq,lt} result encodings; RES_NONE = no result
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/cmp_bit_cell.sv
// cmp_bit_cell: combinational 1-bit magnitude compare.
//   a_bit, b_bit : input bits
//   gt/eq/lt     : one-hot relation of a_bit to b_bit
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;
  assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial unsigned N-bit magnitude comparator.
// Operands are accepted over in_valid/in_ready, walked MSB-first one bit per
// clock through a single cmp_bit_cell, and the one-hot result is returned over
// out_valid/out_ready. The result is held stable until the consumer accepts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   a, b                : WIDTH-bit unsigned operands
//   out_valid, out_ready: result handshake
//   gt, eq, lt          : one-hot result, zero unless out_valid
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first
// differing bit is seen instead of always walking all WIDTH bits.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic [2:0]       res_q, res_d;

  logic cell_gt, cell_eq, cell_lt;

  cmp_bit_cell u_cell (
    .a_bit (sa_q[WIDTH-1]),
    .b_bit (sb_q[WIDTH-1]),
    .gt    (cell_gt),
    .eq    (cell_eq),
    .lt    (cell_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    res_d     = res_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d      = a;
          sb_d      = b;
          idx_d     = CNT_W'(WIDTH - 1);
          decided_d = 1'b0;
          res_d     = RES_NONE;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Only the first differing bit may set the result; once decided,
        // the remaining (less significant) bits are don't-cares.
        if (!decided_q && !cell_eq) begin
          decided_d = 1'b1;
          res_d     = cell_gt ? RES_GT : RES_LT;
        end
        sa_d = sa_q << 1;
        sb_d = sb_q << 1;
        // Counter saturates at zero so it can never wrap.
        if (idx_q != '0) begin
          idx_d = idx_q - CNT_W'(1);
        end
        if (idx_q == '0) begin
          state_d = DONE;
          if (!decided_q && cell_eq) begin
            res_d = RES_EQ;
          end
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (!decided_q && !cell_eq) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          res_d   = RES_NONE;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // res_q carries the gt/lt decision while still shifting; expose it only
  // once the result is complete.
  assign {gt, eq, lt} = out_valid ? res_q : RES_NONE;

  // The cell's lt output is implied by gt/eq; keep it connected for clarity.
  logic unused_cell_lt;
  assign unused_cell_lt = cell_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic             gt, eq, lt;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int acc_cycle = 0;
  int pop_cycle = 0;
  int acc_count = 0;
  int pop_count = 0;
  int rises = 0;
  bit busy = 0;
  bit seen = 0;
  bit acc_pre = 0;
  bit pop_pre = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return WIDTH - i;
    end
`endif
    return WIDTH;
  endfunction

  // Monitor: samples handshakes mid-cycle, checks outputs just after each edge.
  always begin
    @(negedge clk);
    #1;
    acc_pre = rst_n && in_valid && in_ready;
    pop_pre = rst_n && out_valid && out_ready;
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n) begin
      busy = 0;
      seen = 0;
    end else begin
      if (pop_pre) begin
        pop_cycle = cycle;
        pop_count++;
        check("pop_valid_clr", 32'(out_valid), 32'd0);
        check("pop_res_clr", 32'({gt, eq, lt}), 32'd0);
        check("pop_in_ready", 32'(in_ready), 32'd1);
        busy = 0;
        seen = 0;
      end
      if (acc_pre) begin
        acc_cycle = cycle;
        acc_count++;
        busy = 1;
        seen = 0;
      end
      if (busy) begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && !seen) begin
          seen = 1;
          rises++;
          if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            cur.res = 3'b000;
            cur.lat = 0;
          end else begin
            cur = sb.pop_front();
          end
          $display("result #%0d: gt/eq/lt=%b latency=%0d (exp %b / %0d)",
                   rises, {gt, eq, lt}, cycle - acc_cycle, cur.res, cur.lat);
          check("latency", 32'(cycle - acc_cycle), 32'(cur.lat));
          check("result", 32'({gt, eq, lt}), 32'(cur.res));
        end else if (out_valid) begin
          check("result_stable", 32'({gt, eq, lt}), 32'(cur.res));
        end else if (seen) begin
          check("valid_held", 32'(out_valid), 32'd1);
        end
      end else begin
        check("idle_no_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
      end
    end
  end

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    in_valid = 1'b1;
    a_in     = x;
    b_in     = y;
    e.res    = model_res(x, y);
    e.lat    = model_lat(x, y);
    sb.push_back(e);
  endtask

  task automatic wait_acc(input int n0, input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_count > n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_pop(input int n0, input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pop_count > n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'({gt, eq, lt}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. reset mid-SHIFT aborts the operation
    out_ready = 1'b1;
    n = acc_count;
    drive(8'h5A, 8'h5B);
    wait_acc(n, "t1_accept");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n = rises;
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(out_valid), 32'd0);
    check("t1_rst_res", 32'({gt, eq, lt}), 32'd0);
    check("t1_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t1_no_result", 32'(rises), 32'(n));

    // 2..4. single pairs, consumer always ready
    n = pop_count;
    drive(8'h3C, 8'h3C);
    wait_acc(acc_count, "t2_accept");
    in_valid = 1'b0;
    wait_pop(n, "t2_pop");

    n = pop_count;
    drive(8'h80, 8'h7F);
    wait_acc(acc_count, "t3_accept");
    in_valid = 1'b0;
    wait_pop(n, "t3_pop");

    n = pop_count;
    drive(8'h00, 8'h01);
    wait_acc(acc_count, "t4_accept");
    in_valid = 1'b0;
    wait_pop(n, "t4_pop");

    // 5. backpressure with a second pair held on the input the whole time
    out_ready = 1'b0;
    n = acc_count;
    drive(8'hF0, 8'h0F);
    wait_acc(n, "t5_accept");
    drive(8'h00, 8'hFF);
    wait_valid("t5_valid");
    repeat (5) @(negedge clk);
    check("t5_not_accepted", 32'(acc_count), 32'(n + 1));
    out_ready = 1'b1;
    n = pop_count;
    wait_pop(n, "t5_pop");
    wait_acc(acc_count, "t5_accept2");
    in_valid = 1'b0;
    check("t5_accept_after_pop", 32'(acc_cycle), 32'(pop_cycle + 1));
    n = pop_count;
    wait_pop(n, "t5_pop2");

    // 6. back-to-back pairs
    n = rises;
    drive(8'h01, 8'h02);
    wait_acc(acc_count, "t6_accept");
    drive(8'hFF, 8'hFE);
    wait_pop(pop_count, "t6_pop");
    wait_acc(acc_count, "t6_accept2");
    in_valid = 1'b0;
    check("t6_accept_after_pop", 32'(acc_cycle), 32'(pop_cycle + 1));
    wait_pop(pop_count, "t6_pop2");
    repeat (3) @(negedge clk);
    check("t6_pulses", 32'(rises), 32'(n + 2));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
